// File: rtl/mcycle_scheduler_if.sv
// Execute/Write-back side signals of the MUL/DIV scheduler.
// The scheduler uses the slave modport; the pipeline side uses master.
interface mcycle_scheduler_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start_MCycle_E;
    logic             MCycleOp_E;
    logic [3:0]       WA3_E;
    logic             RegWrite_E;
    logic [WIDTH-1:0] Result_Unit;
    logic             RegWriteW;

    logic             Start_Unit;
    logic             Op_Unit;
    logic             Busy_MCycle_E;
    logic [3:0]       WA3_E_MCycle;
    logic             RegWrite_E_MCycle;
    logic             MCycleStructStall;
    logic             MCycleResultstall;
    logic             WE_WB_MCycle;
    logic             WB_Sel;
    logic [3:0]       WA3_WB;
    logic [WIDTH-1:0] WD_WB;

    modport slave (
        input  Start_MCycle_E, MCycleOp_E, WA3_E, RegWrite_E, Result_Unit, RegWriteW,
        output Start_Unit, Op_Unit, Busy_MCycle_E, WA3_E_MCycle, RegWrite_E_MCycle,
               MCycleStructStall, MCycleResultstall, WE_WB_MCycle, WB_Sel, WA3_WB, WD_WB
    );

    modport master (
        output Start_MCycle_E, MCycleOp_E, WA3_E, RegWrite_E, Result_Unit, RegWriteW,
        input  Start_Unit, Op_Unit, Busy_MCycle_E, WA3_E_MCycle, RegWrite_E_MCycle,
               MCycleStructStall, MCycleResultstall, WE_WB_MCycle, WB_Sel, WA3_WB, WD_WB
    );
endinterface

// File: rtl/mcycle_scheduler.sv
// Sequences the fixed-latency MUL/DIV unit and arbitrates the register-file write port.
// Define MCYCLE_PERF_EN to add saturating stall-cycle counters.
module mcycle_scheduler #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    mcycle_scheduler_if.slave        bus_io
`ifdef MCYCLE_PERF_EN
    ,
    output logic [15:0]              PerfResultStall,
    output logic [15:0]              PerfStructStall
`endif
);
    localparam logic [5:0] MulCnt = 6'(MUL_CYCLES);
    localparam logic [5:0] DivCnt = 6'(DIV_CYCLES);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [5:0]       cnt_q;
    logic             op_q;
    logic [3:0]       wa3_q;
    logic             rw_q;
    logic [WIDTH-1:0] wd_q;

    logic idle, busy, commit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            wa3_q   <= '0;
            rw_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.Start_MCycle_E) begin
                        op_q    <= bus_io.MCycleOp_E;
                        wa3_q   <= bus_io.WA3_E;
                        rw_q    <= bus_io.RegWrite_E;
                        cnt_q   <= bus_io.MCycleOp_E ? DivCnt : MulCnt;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        wd_q    <= bus_io.Result_Unit;
                        state_q <= rw_q ? StDone : StIdle;
                    end
                end
                StDone: begin
                    if (!bus_io.RegWriteW) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign idle   = (state_q == StIdle);
    assign busy   = !idle;
    assign commit = (state_q == StDone) && !bus_io.RegWriteW;

    // RESET gates the start pulse so an asserted reset never launches the datapath.
    assign bus_io.Start_Unit        = RESET && idle && bus_io.Start_MCycle_E;
    assign bus_io.Op_Unit           = op_q;
    assign bus_io.Busy_MCycle_E     = busy;
    assign bus_io.WA3_E_MCycle      = busy ? wa3_q : 4'd0;
    assign bus_io.RegWrite_E_MCycle = busy && rw_q;
    assign bus_io.MCycleStructStall = bus_io.Start_MCycle_E && busy;
    assign bus_io.MCycleResultstall = (state_q == StDone) && bus_io.RegWriteW;
    assign bus_io.WE_WB_MCycle      = commit;
    assign bus_io.WB_Sel            = commit;
    assign bus_io.WA3_WB            = wa3_q;
    assign bus_io.WD_WB             = wd_q;

`ifdef MCYCLE_PERF_EN
    logic [15:0] perf_res_q, perf_struct_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_res_q    <= '0;
            perf_struct_q <= '0;
        end else begin
            if (bus_io.MCycleResultstall && (perf_res_q != 16'hFFFF)) begin
                perf_res_q <= perf_res_q + 16'd1;
            end
            if (bus_io.MCycleStructStall && (perf_struct_q != 16'hFFFF)) begin
                perf_struct_q <= perf_struct_q + 16'd1;
            end
        end
    end

    assign PerfResultStall = perf_res_q;
    assign PerfStructStall = perf_struct_q;
`endif
endmodule

// File: tb/tb_mcycle_scheduler.sv
// Scoreboard bench for mcycle_scheduler: expected writes are queued at capture time
// and popped by a monitor whenever the scheduler commits a write.
module tb_mcycle_scheduler;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [35:0] exp_q[$];

    mcycle_scheduler_if #(.WIDTH(32)) bus ();

`ifdef MCYCLE_PERF_EN
    logic [15:0] perf_res, perf_struct;
`endif

    mcycle_scheduler #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(33),
        .WIDTH(32)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus_io(bus)
`ifdef MCYCLE_PERF_EN
        ,
        .PerfResultStall(perf_res),
        .PerfStructStall(perf_struct)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        bus.Result_Unit = $urandom;
    endtask

    function automatic logic [47:0] all_outs();
        return {bus.Start_Unit, bus.Op_Unit, bus.Busy_MCycle_E, bus.WA3_E_MCycle,
                bus.RegWrite_E_MCycle, bus.MCycleStructStall, bus.MCycleResultstall,
                bus.WE_WB_MCycle, bus.WB_Sel, bus.WA3_WB, bus.WD_WB};
    endfunction

    // Write-port monitor: every commit must match the oldest queued result.
    always @(negedge CLK) begin
        if (RESET && bus.WE_WB_MCycle) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_we", 64'(bus.WE_WB_MCycle), 64'd0);
            end else begin
                check_eq("wb_data", 64'({bus.WA3_WB, bus.WD_WB}), 64'(exp_q.pop_front()));
                check_eq("wb_sel", 64'(bus.WB_Sel), 64'd1);
            end
        end
    end

    // Caller positions us at the start of the issue cycle.
    task automatic run_op(input bit op, input logic [3:0] wa, input bit rw, input int hold);
        int lat;
        logic [31:0] res;
        lat = op ? 33 : 4;
        bus.Start_MCycle_E = 1'b1;
        bus.MCycleOp_E     = op;
        bus.WA3_E          = wa;
        bus.RegWrite_E     = rw;
        #1;
        check_eq("start_pulse", 64'(bus.Start_Unit), 64'd1);
        check_eq("issue_busy", 64'(bus.Busy_MCycle_E), 64'd0);
        check_eq("issue_struct", 64'(bus.MCycleStructStall), 64'd0);
        for (int k = 1; k <= lat; k++) begin
            step();
            bus.Start_MCycle_E = 1'b0;
            bus.WA3_E          = 4'($urandom);
            bus.MCycleOp_E     = 1'($urandom);
            res                = bus.Result_Unit;
            #1;
            check_eq("run_busy", 64'(bus.Busy_MCycle_E), 64'd1);
            check_eq("run_start", 64'(bus.Start_Unit), 64'd0);
            check_eq("run_op", 64'(bus.Op_Unit), 64'(op));
            check_eq("run_wa3", 64'(bus.WA3_E_MCycle), 64'(wa));
            check_eq("run_rw", 64'(bus.RegWrite_E_MCycle), 64'(rw));
            check_eq("run_we", 64'(bus.WE_WB_MCycle), 64'd0);
        end
        if (rw) begin
            exp_q.push_back({wa, res});
            for (int h = 0; h < hold; h++) begin
                step();
                bus.RegWriteW = 1'b1;
                #1;
                check_eq("hold_rstall", 64'(bus.MCycleResultstall), 64'd1);
                check_eq("hold_we", 64'(bus.WE_WB_MCycle), 64'd0);
                check_eq("hold_busy", 64'(bus.Busy_MCycle_E), 64'd1);
            end
            step();
            bus.RegWriteW = 1'b0;
            #1;
            check_eq("commit_we", 64'(bus.WE_WB_MCycle), 64'd1);
            check_eq("commit_rstall", 64'(bus.MCycleResultstall), 64'd0);
            check_eq("commit_busy", 64'(bus.Busy_MCycle_E), 64'd1);
        end
        step();
        #1;
        check_eq("after_busy", 64'(bus.Busy_MCycle_E), 64'd0);
        check_eq("after_we", 64'(bus.WE_WB_MCycle), 64'd0);
        check_eq("after_wa3", 64'(bus.WA3_E_MCycle), 64'd0);
    endtask

    initial begin
        logic [31:0] res;
        bus.Start_MCycle_E = 1'b0;
        bus.MCycleOp_E     = 1'b0;
        bus.WA3_E          = 4'd0;
        bus.RegWrite_E     = 1'b0;
        bus.Result_Unit    = 32'd0;
        bus.RegWriteW      = 1'b0;
        #2;
        check_eq("reset_outs", 64'(all_outs()), 64'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        step();

        run_op(1'b0, 4'd5, 1'b1, 0);   // MUL, immediate write in t+5
        run_op(1'b1, 4'd12, 1'b1, 0);  // DIV, write in t+34
        run_op(1'b0, 4'd2, 1'b1, 2);   // port held by pipeline for 2 cycles
`ifdef MCYCLE_PERF_EN
        check_eq("perf_res", 64'(perf_res), 64'd2);
`endif

        // Second start arrives while the first MUL is in flight.
        bus.Start_MCycle_E = 1'b1;
        bus.MCycleOp_E     = 1'b0;
        bus.WA3_E          = 4'd3;
        bus.RegWrite_E     = 1'b1;
        #1;
        check_eq("s_start", 64'(bus.Start_Unit), 64'd1);
        res = 32'd0;
        for (int k = 1; k <= 4; k++) begin
            step();
            bus.WA3_E = 4'd7;
            res       = bus.Result_Unit;
            #1;
            check_eq("s_struct", 64'(bus.MCycleStructStall), 64'd1);
            check_eq("s_nostart", 64'(bus.Start_Unit), 64'd0);
        end
        exp_q.push_back({4'd3, res});
        step();
        #1;
        check_eq("s_commit_struct", 64'(bus.MCycleStructStall), 64'd1);
        check_eq("s_commit_we", 64'(bus.WE_WB_MCycle), 64'd1);
        check_eq("s_commit_nostart", 64'(bus.Start_Unit), 64'd0);
        step();
        run_op(1'b0, 4'd7, 1'b1, 0);
`ifdef MCYCLE_PERF_EN
        check_eq("perf_struct", 64'(perf_struct), 64'd5);
`endif

        run_op(1'b0, 4'd9, 1'b0, 0);   // no write-back expected
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset during RUN cycle 2 of a DIV.
        bus.Start_MCycle_E = 1'b1;
        bus.MCycleOp_E     = 1'b1;
        bus.WA3_E          = 4'd11;
        bus.RegWrite_E     = 1'b1;
        step();
        bus.Start_MCycle_E = 1'b0;
        step();
        #1;
        check_eq("pre_reset_busy", 64'(bus.Busy_MCycle_E), 64'd1);
        RESET = 1'b0;
        #1;
        check_eq("mid_reset_outs", 64'(all_outs()), 64'd0);
`ifdef MCYCLE_PERF_EN
        check_eq("perf_res_clr", 64'(perf_res), 64'd0);
        check_eq("perf_struct_clr", 64'(perf_struct), 64'd0);
`endif
        step();
        step();
        RESET = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            #1;
            check_eq("post_reset_we", 64'(bus.WE_WB_MCycle), 64'd0);
            check_eq("post_reset_busy", 64'(bus.Busy_MCycle_E), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
